// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Imported by the scheduler top and its arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RELEASE
  } sched_st_t;

  localparam int UART_W      = 8;
  localparam int DEF_BAUD    = 9600;
  localparam int DEF_TIMEOUT = 2_000_000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester
// strictly after last_gnt, with wrap-around.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic            any,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] j;

  always_comb begin
    any     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = last_gnt;
    j       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      j = IW'((int'(last_gnt) + off) % NREQ);
      if (!any && req[j]) begin
        any        = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, message-locked scheduler sharing one UART transmitter,
// with a level start/done handshake and a timeout watchdog.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = UART_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] grant,
  output logic            tx_start,
  output logic [W-1:0]    tx_data,
  input  logic            tx_done,
  output logic            busy,
  output logic            err
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_st_t state, nxt;

  logic            done_m, done_s;
  logic [IW-1:0]   last_gnt;
  logic            last_flag;
  logic [CW-1:0]   cnt;
  logic            tmo;
  logic            own_valid;
  logic            ld_gnt, clr_gnt;

  logic            arb_any;
  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .any      (arb_any),
    .gnt_oh   (arb_oh),
    .gnt_idx  (arb_idx)
  );

  // tx_done comes from the divided transmitter clock
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= tx_done;
      done_s <= done_m;
    end
  end

  assign tmo       = (cnt == CW'(TIMEOUT));
  assign own_valid = req_valid[last_gnt];

  always_comb begin
    nxt     = state;
    ld_gnt  = 1'b0;
    clr_gnt = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          ld_gnt = 1'b1;
          nxt    = LOAD;
        end
      end
      LOAD: nxt = START;
      START: begin
        if (done_s) begin
          nxt = RELEASE;
        end else if (tmo) begin
          err = 1'b1;
          nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!done_s || tmo) begin
          err = done_s;
          if (!last_flag && own_valid) begin
            nxt = LOAD;
          end else begin
            clr_gnt = 1'b1;
            nxt     = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= nxt;
  end

  // Counter restarts on every state change and saturates.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)              cnt <= '0;
    else if (nxt != state)   cnt <= '0;
    else if (!tmo)           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      grant    <= '0;
      last_gnt <= IW'(NREQ - 1);
    end else if (ld_gnt) begin
      grant    <= arb_oh;
      last_gnt <= arb_idx;
    end else if (clr_gnt) begin
      grant    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tx_data   <= '0;
      last_flag <= 1'b0;
    end else if (state == LOAD) begin
      tx_data   <= req_data[int'(last_gnt)*W +: W];
      last_flag <= req_last[last_gnt];
    end
  end

  assign req_ready = (state == LOAD) ? grant : '0;
  assign tx_start  = (state == START);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a message-level
// round-robin model and an asynchronous transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int TMO  = 50;
  localparam int BUF  = 512;

  logic            clk, rst_l;
  logic [NREQ-1:0] req_valid, req_last, req_ready, grant;
  logic [NREQ*W-1:0] req_data;
  logic            tx_start, tx_done, busy, err;
  logic [W-1:0]    tx_data;

  uart_tx_sched #(
    .NREQ    (NREQ),
    .W       (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .err       (err)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] sbuf [NREQ][BUF];
  int         swr [NREQ];
  int         srd [NREQ];
  logic [8:0] mbuf [NREQ][BUF];
  int         mwr [NREQ];
  int         mrd [NREQ];
  int         mptr;
  int         expq [$];
  int         exp_rdy, rdy_cnt, err_cnt, exp_err;
  logic       stall;

  task automatic add_byte(input int r, input logic [7:0] b, input logic l);
    sbuf[r][swr[r]] = {l, b};
    swr[r]++;
    mbuf[r][mwr[r]] = {l, b};
    mwr[r]++;
  endtask

  // Model: whole messages granted in rotating order among pending requesters.
  task automatic schedule();
    int w;
    bit found;
    logic [8:0] e;
    forever begin
      found = 0;
      w = 0;
      for (int off = 1; off <= NREQ; off++) begin
        int j;
        j = (mptr + off) % NREQ;
        if (!found && mrd[j] < mwr[j]) begin
          found = 1;
          w = j;
        end
      end
      if (!found) break;
      mptr = w;
      do begin
        e = mbuf[w][mrd[w]];
        mrd[w]++;
        expq.push_back(w * 256 + int'(e[7:0]));
        exp_rdy++;
      end while (!e[8] && mrd[w] < mwr[w]);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy && expq.size() == 0;
      for (int r = 0; r < NREQ; r++)
        if (srd[r] != swr[r]) ok = 0;
    end
    if (!ok) chk("drain", 0, 1);
  endtask

  task automatic wait_start(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = tx_start;
    end
    if (!ok) chk("start_wait", 0, 1);
  endtask

  // Requesters: present the head byte, advance one negedge after req_ready.
  initial begin
    bit adv [NREQ];
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int r = 0; r < NREQ; r++) adv[r] = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        if (!rst_l) adv[r] = 0;
        else if (adv[r]) begin
          srd[r]++;
          adv[r] = 0;
        end
        if (rst_l && req_ready[r]) adv[r] = 1;
        if (srd[r] < swr[r]) begin
          req_valid[r]       = 1'b1;
          req_data[r*W +: W] = sbuf[r][srd[r]][7:0];
          req_last[r]        = sbuf[r][srd[r]][8];
        end else begin
          req_valid[r]       = 1'b0;
          req_data[r*W +: W] = '0;
          req_last[r]        = 1'b0;
        end
      end
    end
  end

  // Transmitter on its own clock: done follows start after a random delay.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge tx_start);
      if (!stall) begin
        #($urandom_range(3, 40));
        if (tx_start) tx_done = 1'b1;
        wait (!tx_start || !rst_l);
        #($urandom_range(3, 40));
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    logic prev;
    int e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      rdy_cnt += $countones(req_ready);
      if (err) err_cnt++;
      if (rst_l && !busy) chk("idle_gnt", 32'(grant), 0);
      if (tx_start && !prev) begin
        if (expq.size() == 0) chk("extra_byte", 1, 0);
        else begin
          e = expq.pop_front();
          chk("byte", 32'(tx_data), e % 256);
          chk("gnt", 32'(grant), 1 << (e / 256));
        end
      end
      prev = tx_start;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    for (int r = 0; r < NREQ; r++) begin
      swr[r] = 0;
      srd[r] = 0;
      mwr[r] = 0;
      mrd[r] = 0;
    end
    expq.delete();
    mptr = NREQ - 1;
  endtask

  initial begin
    int n;
    bit seen;
    stall   = 1'b0;
    exp_rdy = 0;
    rdy_cnt = 0;
    err_cnt = 0;
    exp_err = 0;
    clear_all();
    rst_l = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    #20;
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Single message from requester 0
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b1);
    schedule();
    wait_drain(500);
    chk("single_rdy", 32'(rdy_cnt), 2);

    // Lock: requester 1 arrives mid-message
    add_byte(0, 8'h51, 1'b0);
    add_byte(0, 8'h52, 1'b0);
    add_byte(0, 8'h53, 1'b1);
    schedule();
    wait_start(100);
    add_byte(1, 8'h61, 1'b0);
    add_byte(1, 8'h62, 1'b1);
    schedule();
    wait_drain(800);

    // Early end: requester 1 stops without req_last
    add_byte(1, 8'h55, 1'b0);
    add_byte(0, 8'h66, 1'b0);
    add_byte(0, 8'h67, 1'b1);
    schedule();
    wait_drain(800);

    // Randomized rounds with simultaneous requests
    for (int rd = 0; rd < 20; rd++) begin
      for (int r = 0; r < NREQ; r++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            add_byte(r, 8'($urandom), b == len - 1);
        end
      end
      schedule();
      wait_drain(3000);
    end

    // Timeout with a stuck transmitter
    stall = 1'b1;
    add_byte(1, 8'hA5, 1'b1);
    schedule();
    wait_start(100);
    seen = 0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = err;
    end
    exp_err++;
    chk("tmo_cycles", 32'(n), TMO);
    @(negedge clk);
    chk("tmo_start", 32'(tx_start), 0);
    chk("tmo_err_pulse", 32'(err), 0);
    wait_drain(100);
    chk("errs", 32'(err_cnt), 32'(exp_err));
    chk("readys", 32'(rdy_cnt), 32'(exp_rdy));

    // Asynchronous reset while in START
    add_byte(1, 8'hC3, 1'b1);
    schedule();
    wait_start(100);
    #2;
    rst_l = 1'b0;
    #1;
    chk("arst_start", 32'(tx_start), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_busy", 32'(busy), 0);
    clear_all();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    add_byte(0, 8'h31, 1'b1);
    add_byte(1, 8'h32, 1'b1);
    schedule();
    wait_drain(800);
    chk("final_errs", 32'(err_cnt), 32'(exp_err));
    chk("final_readys", 32'(rdy_cnt), 32'(exp_rdy));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter between `NREQ` byte-stream requesters. It grants one requester at a time and locks the grant for a whole message, delimited by `req_last`. For each byte it drives the transmitter's level start/done handshake. It sits between the Morse encoder / status message sources and the transmitter, and adds a timeout watchdog so a stuck transmitter cannot hang the design.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `W`, 8: byte width; must match the transmitter's data width.
- `TIMEOUT`, 2_000_000: `clk` cycles allowed in `START` or `RELEASE` before abort.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_l`  in  1  reset `rst_l`, asynchronous, active-low; clock `clk`.
- `req_valid`  in  NREQ  requester i has a byte on its slice of `req_data`.
- `req_data`  in  NREQ*W  byte of requester i at bits [i*W +: W].
- `req_last`  in  NREQ  the offered byte is the last byte of the message.
- `req_ready`  out  NREQ  one-cycle pulse; the offered byte is captured.
- `grant`  out  NREQ  one-hot owner of the transmitter; all zero when idle.
- `tx_start`  out  1  level start to the transmitter.
- `tx_data`  out  W  byte to the transmitter; stable while `tx_start`=1.
- `tx_done`  in  1  transmitter done level; asynchronous to `clk` (divided clock domain).
- `busy`  out  1  state is not IDLE.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- `tx_done` passes through a 2-flop synchronizer; the result is `done_s`. All decisions use `done_s`.
- Round-robin pointer `last_gnt` (index). On arbitration, search from `last_gnt`+1 upward with wrap and pick the first `req_valid`. `last_gnt` updates to the winner.
- States:
  - IDLE: `grant`=0. If any `req_valid`, register the winner into `grant` and go to LOAD.
  - LOAD (1 cycle): `req_ready[owner]`=1; `tx_data` <= owner byte; `last_flag` <= `req_last[owner]`; go to START.
  - START: `tx_start`=1. On `done_s`=1, go to RELEASE. On timeout, pulse `err` and go to RELEASE.
  - RELEASE: `tx_start`=0. Wait for `done_s`=0, or timeout; a timeout here also pulses `err`. Then:
    - if `last_flag`=0 and `req_valid[owner]`=1, go to LOAD with the same owner;
    - otherwise clear `grant` and go to IDLE.
- An owner dropping `req_valid` mid-message ends its lock; this is not an error.
- A timeout in START drops the byte (no retry); the message continues with the next byte.
- The timeout counter clears on every state entry. It saturates at `TIMEOUT`. Its width is $clog2(TIMEOUT+1).
- `req_valid`/`req_data` of non-owners are ignored. Requesters must hold `req_data` stable while `req_valid`=1 until `req_ready`.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0, `busy`=0, `err`=0, state IDLE, `last_gnt`=NREQ-1 (requester 0 wins first).
- Reset mid-transfer: `tx_start` drops immediately (asynchronous) and the lock is lost. The transmitter is reset by the same `rst_l`.
- Sequence from `req_valid` high in IDLE at edge k:
  - `grant` and LOAD at k+1;
  - `req_ready` high during cycle k+1;
  - `tx_start`=1 from k+2.
- `done_s` lags `tx_done` by 2 edges. `tx_start` falls 1 edge after `done_s` rises.
- Back-to-back bytes of one message: the next LOAD follows the RELEASE exit by 1 cycle. No IDLE gap.
- Between messages: at least 1 IDLE cycle, with `grant`=0.
- If `req_valid` rises for several requesters in the same cycle, round-robin order applies. If only the previous owner requests, it is granted again.
- `req_last` is sampled only in LOAD.

## Structure
- Package `uart_pkg`: state enum (IDLE, LOAD, START, RELEASE), `UART_W`=8, `DEF_BAUD`=9600, `DEF_TIMEOUT`.
- Sub-module `rr_arbiter`: combinational next-grant from `req_valid` and `last_gnt`. It outputs one-hot plus index.
- The synchronizer stays inline.

## Test plan
- Single message: requester 0 sends 0x41, 0x42 with `req_last` on 0x42 → `tx_data` 0x41 then 0x42. `tx_start` toggles twice. Exactly 2 `req_ready` pulses. `grant`=01 held throughout, then 00.
- Contention: requesters 0 and 1 each send a 2-byte message, both valid at the same edge → order 0,0,1,1. A second round with both valid → 0 wins again, since `last_gnt`=1.
- Lock: requester 1 valid while requester 0 is mid-message → no interleave; requester 1 is granted only after requester 0's last byte.
- Timeout: with `TIMEOUT`=50, hold `tx_done`=0 → `err` pulses 50 cycles after START entry, `tx_start` drops, and the scheduler returns to IDLE.
- Reset: assert `rst_l` low while in START → `tx_start`, `grant` and `busy` are 0 with no clock edge. After release, requester 0 is granted first.
- Early end: owner drops `req_valid` after byte 1 with `req_last`=0 → goes to IDLE after RELEASE with no error, and the other requester is granted next.
